// File: rtl/intr_ctrl.sv
// intr_ctrl: requesting side of the Intr/Inta interrupt handshake.
// Latches rising edges on Irq into Pending, offers the lowest-index enabled
// pending line on Intr/IrqId, and holds that ID while it is being serviced
// until the handler signals end-of-interrupt on Eoi.
//
// Handshake: Intr is a level held from the cycle a request is offered until
// the clock that samples Inta=1 (one-cycle acknowledge pulse). Inta is only
// honoured while Intr is high; Eoi is only honoured while Busy is high. Both
// are sampled on the rising edge of Clk, and no output depends
// combinationally on any input.
module intr_ctrl #(
  parameter int N_IRQ = 8,
  parameter int IDW   = 3
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [N_IRQ-1:0] Irq,
  input  logic             Wien,
  input  logic [N_IRQ-1:0] IenIn,
  input  logic             Inta,
  input  logic             Eoi,
  output logic             Intr,
  output logic [IDW-1:0]   IrqId,
  output logic [N_IRQ-1:0] Pending,
  output logic [N_IRQ-1:0] Ien,
  output logic             Busy,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           state;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] irq_edge;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] ack_clr;
  logic [IDW-1:0]   win_id;
  logic             win_valid;
  logic             ack;

  assign fsm_state = state;
  assign irq_edge  = Irq & ~irq_q;
  assign eligible  = Pending & Ien;
  assign ack       = (state == S_REQ) && Inta;

  // Lowest-index eligible line wins; scanning downward lets lower indices overwrite.
  always_comb begin
    win_id    = '0;
    win_valid = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id    = IDW'(i);
        win_valid = 1'b1;
      end
    end
  end

  // One-hot clear of the line being acknowledged this cycle.
  always_comb begin
    ack_clr = '0;
    if (ack) ack_clr[IrqId] = 1'b1;
  end

  // Registered copy of Irq for rising-edge detection.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) irq_q <= '0;
    else       irq_q <= Irq;
  end

  // Pending: a new edge wins over a same-cycle acknowledge clear.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) Pending <= '0;
    else       Pending <= (Pending & ~ack_clr) | irq_edge;
  end

  // Enable register, writable in every state; masking never touches Pending.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)     Ien <= '0;
    else if (Wien) Ien <= IenIn;
  end

  // Handshake FSM with registered Intr/Busy/IrqId; IrqId only changes on capture.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state <= S_IDLE;
      Intr  <= 1'b0;
      Busy  <= 1'b0;
      IrqId <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            IrqId <= win_id;
            Intr  <= 1'b1;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (Inta) begin
            Intr  <= 1'b0;
            Busy  <= 1'b1;
            state <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (Eoi) begin
            Busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          Intr  <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
